pmem_write_buffer: RTL and testbench

Line-granular write-back buffer between the L2 cache's downstream port and physical memory. L2 evictions are absorbed in one cycle and drained to memory in the background. L2 read misses bypass queued writes, and reads that hit a buffered line are forwarded locally. Both the upstream and downstream interfaces use the held-request / one-cycle-resp protocol of the cache hierarchy.

---
 rtl/pmem_write_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_pmem_write_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_write_buffer.sv
// Line-granular write-back buffer between L2 and physical memory: evictions are
// absorbed into a small FIFO and drained in the background; read misses bypass it.
module pmem_write_buffer #(
  parameter int DEPTH    = 2,
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_line-1:0] mem_wdata,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CW-1:0]     o_dbg_count,
  output logic [1:0]        o_dbg_u_state,
  output logic              o_dbg_d_state
);

  localparam int LW = 32 - s_offset;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {U_IDLE, U_WAIT, U_RD, U_RESP} u_state_t;
  typedef enum logic {D_IDLE, D_WR} d_state_t;

  // Upstream (L2 side) and downstream (memory side) both follow one handshake:
  // a request is held high until the responder pulses resp for exactly one
  // cycle; data accompanying a request stays stable until that pulse.

  u_state_t          r_u_state;
  d_state_t          r_d_state;
  logic [LW-1:0]     r_line  [DEPTH];
  logic [s_line-1:0] r_data  [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              r_mem_resp;
  logic [s_line-1:0] r_mem_rdata;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [31:0]       r_rd_addr;
  logic [31:0]       r_wr_addr;
  logic [s_line-1:0] r_pmem_wdata;

  logic [31:0]   w_line_addr;
  logic [LW-1:0] w_req_line;
  logic          w_hit;
  logic [PW-1:0] w_hit_idx;
  logic          w_u_idle;
  logic          w_head_busy;
  logic          w_coal;
  logic          w_enq;
  logic          w_rd_hit;
  logic          w_rd_miss;
  logic          w_deq;
  logic          w_drain_go;

  assign w_line_addr = mem_address & LINE_MASK;
  assign w_req_line  = mem_address[31:s_offset];

  // Line addresses in the buffer are unique, so at most one entry matches.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_line[i] == w_req_line)) begin
        w_hit     = 1'b1;
        w_hit_idx = PW'(i);
      end
    end
  end

  assign w_u_idle    = (r_u_state == U_IDLE);
  assign w_head_busy = (r_d_state == D_WR) && w_hit && (w_hit_idx == r_head);
  assign w_coal      = w_u_idle && mem_write && w_hit && !w_head_busy;
  assign w_enq       = w_u_idle && mem_write && !w_hit && (r_count < CW'(DEPTH));
  assign w_rd_hit    = w_u_idle && mem_read && w_hit;
  assign w_rd_miss   = w_u_idle && mem_read && !w_hit;
  assign w_deq       = (r_d_state == D_WR) && pmem_resp;
  assign w_drain_go  = (r_d_state == D_IDLE) && (r_count != '0) &&
                       (r_u_state != U_WAIT) && (r_u_state != U_RD);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_line[r_tail] <= w_req_line;
      r_data[r_tail] <= mem_wdata;
    end else if (w_coal) begin
      r_data[w_hit_idx] <= mem_wdata;
    end
  end

  // An enqueue never targets the head entry while a dequeue is possible,
  // so the two valid-bit updates below never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u_state   <= U_IDLE;
      r_mem_resp  <= 1'b0;
      r_mem_rdata <= '0;
      r_pmem_read <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      case (r_u_state)
        U_IDLE: begin
          if (w_coal || w_enq) begin
            r_u_state  <= U_RESP;
            r_mem_resp <= 1'b1;
          end else if (w_rd_hit) begin
            r_u_state   <= U_RESP;
            r_mem_resp  <= 1'b1;
            r_mem_rdata <= r_data[w_hit_idx];
          end else if (w_rd_miss) begin
            r_u_state <= U_WAIT;
            r_rd_addr <= w_line_addr;
          end
        end
        U_WAIT: begin
          // Let an in-flight drain write finish before taking the port.
          if (r_d_state == D_IDLE) begin
            r_u_state   <= U_RD;
            r_pmem_read <= 1'b1;
          end
        end
        U_RD: begin
          if (pmem_resp) begin
            r_u_state   <= U_RESP;
            r_pmem_read <= 1'b0;
            r_mem_rdata <= pmem_rdata;
            r_mem_resp  <= 1'b1;
          end
        end
        U_RESP: begin
          r_u_state  <= U_IDLE;
          r_mem_resp <= 1'b0;
        end
        default: r_u_state <= U_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_state    <= D_IDLE;
      r_pmem_write <= 1'b0;
      r_wr_addr    <= '0;
      r_pmem_wdata <= '0;
    end else begin
      case (r_d_state)
        D_IDLE: begin
          if (w_drain_go) begin
            r_d_state    <= D_WR;
            r_pmem_write <= 1'b1;
            r_wr_addr    <= {r_line[r_head], {s_offset{1'b0}}};
            // A coalesce into the head on this same edge must not be lost.
            r_pmem_wdata <= (w_coal && (w_hit_idx == r_head)) ? mem_wdata
                                                              : r_data[r_head];
          end
        end
        D_WR: begin
          if (pmem_resp) begin
            r_d_state    <= D_IDLE;
            r_pmem_write <= 1'b0;
          end
        end
        default: r_d_state <= D_IDLE;
      endcase
    end
  end

  assign mem_resp      = r_mem_resp;
  assign mem_rdata     = r_mem_rdata;
  assign pmem_read     = r_pmem_read;
  assign pmem_write    = r_pmem_write;
  assign pmem_address  = r_pmem_read ? r_rd_addr : r_wr_addr;
  assign pmem_wdata    = r_pmem_wdata;
  assign o_dbg_count   = r_count;
  assign o_dbg_u_state = r_u_state;
  assign o_dbg_d_state = r_d_state;

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer: L2 driver tasks, a negedge memory model
// with programmable latency, and per-scenario tasks with hand-computed results.
module tb_pmem_write_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_address = '0;
  logic [255:0] mem_wdata = '0;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [1:0]   dbg_count;
  logic [1:0]   dbg_u_state;
  logic         dbg_d_state;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int mem_cnt = 0;
  bit overlap_seen = 1'b0;

  logic [31:0]  wr_addr_log[$];
  logic [255:0] wr_data_log[$];
  logic [31:0]  rd_addr_log[$];

  logic [255:0] dat_a, dat_b, dat_c, dat_d, dat_e;

  pmem_write_buffer #(.DEPTH(2), .s_offset(5), .s_line(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .o_dbg_count(dbg_count), .o_dbg_u_state(dbg_u_state), .o_dbg_d_state(dbg_d_state)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rd_pattern(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // Memory model: counts mem_lat negedges of a held request, then drives a
  // one-cycle resp pulse that the DUT samples on the following posedge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end else if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        pmem_resp = 1'b1;
        if (pmem_write) begin
          wr_addr_log.push_back(pmem_address);
          wr_data_log.push_back(pmem_wdata);
        end else begin
          rd_addr_log.push_back(pmem_address);
          pmem_rdata = rd_pattern(pmem_address);
        end
      end
    end
  end

  always @(negedge clk) if (pmem_read && pmem_write) overlap_seen = 1'b1;

  task automatic l2_write(input logic [31:0] a, input logic [255:0] d, output int lat);
    @(negedge clk);
    mem_address = a;
    mem_wdata   = d;
    mem_write   = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) break;
    end
    mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic l2_read(input logic [31:0] a, output logic [255:0] d, output int lat);
    @(negedge clk);
    mem_address = a;
    mem_read    = 1'b1;
    lat = 0;
    d   = '0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) begin
        d = mem_rdata;
        break;
      end
    end
    mem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drained();
    int n = 0;
    while (!(dbg_count == 2'd0 && dbg_d_state == 1'b0 && !pmem_write && !pmem_resp) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout: count=%0d d_state=%0d still busy after %0d cycles", dbg_count, dbg_d_state, n);
    end
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_addr_log.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL rst_mem_resp: got %b want 0", mem_resp); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_read: got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL rst_pmem_write: got %b want 0", pmem_write); end
    checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL rst_pmem_address: got %h want 0", pmem_address); end
    checks++; if (pmem_wdata !== 256'h0) begin errors++; $display("FAIL rst_pmem_wdata: got %h want 0", pmem_wdata); end
    checks++; if (mem_rdata !== 256'h0) begin errors++; $display("FAIL rst_mem_rdata: got %h want 0", mem_rdata); end
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", dbg_count); end
    checks++; if (dbg_u_state !== 2'd0 || dbg_d_state !== 1'b0) begin errors++; $display("FAIL rst_states: got u=%0d d=%0d want 0 0", dbg_u_state, dbg_d_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int lat, n;
    mem_lat = 3;
    clear_logs();
    l2_write(32'h0000_1040, dat_a, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL sw_latency: got %0d want 1", lat); end
    n = 0;
    while (!pmem_write && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL sw_pmem_write: got %b want 1", pmem_write); end
    checks++; if (pmem_address !== 32'h0000_1040) begin errors++; $display("FAIL sw_pmem_address: got %h want 00001040", pmem_address); end
    checks++; if (pmem_wdata !== dat_a) begin errors++; $display("FAIL sw_pmem_wdata: got %h want %h", pmem_wdata, dat_a); end
    wait_drained();
    checks++; if (wr_addr_log.size() != 1) begin errors++; $display("FAIL sw_log_size: got %0d want 1", wr_addr_log.size()); end
    else if (wr_data_log[0] !== dat_a) begin errors++; $display("FAIL sw_log_data: got %h want %h", wr_data_log[0], dat_a); end
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL sw_count: got %0d want 0", dbg_count); end
  endtask

  task automatic test_read_forward();
    int lat;
    logic [255:0] d;
    mem_lat = 10;
    clear_logs();
    l2_write(32'h0000_0100, dat_a, lat);
    l2_read(32'h0000_0104, d, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL fwd_latency: got %0d want 1", lat); end
    checks++; if (d !== dat_a) begin errors++; $display("FAIL fwd_data: got %h want %h", d, dat_a); end
    wait_drained();
    checks++; if (rd_addr_log.size() != 0) begin errors++; $display("FAIL fwd_no_pmem_read: got %0d reads want 0", rd_addr_log.size()); end
    checks++; if (wr_addr_log.size() != 1) begin errors++; $display("FAIL fwd_write_count: got %0d want 1", wr_addr_log.size()); end
  endtask

  task automatic test_coalesce();
    int lat;
    mem_lat = 10;
    clear_logs();
    l2_write(32'h0000_0100, dat_c, lat);
    l2_write(32'h0000_0200, dat_a, lat);
    l2_write(32'h0000_0200, dat_b, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL coal_latency: got %0d want 1", lat); end
    checks++; if (dbg_count !== 2'd2) begin errors++; $display("FAIL coal_count: got %0d want 2", dbg_count); end
    wait_drained();
    checks++; if (wr_addr_log.size() != 2) begin errors++; $display("FAIL coal_log_size: got %0d want 2", wr_addr_log.size()); end
    else begin
      checks++; if (wr_addr_log[0] !== 32'h100 || wr_data_log[0] !== dat_c) begin errors++; $display("FAIL coal_first: got %h want 00000100", wr_addr_log[0]); end
      checks++; if (wr_addr_log[1] !== 32'h200 || wr_data_log[1] !== dat_b) begin errors++; $display("FAIL coal_second: got %h/%h want 00000200/%h", wr_addr_log[1], wr_data_log[1], dat_b); end
    end
  endtask

  task automatic test_coalesce_stall();
    int lat;
    mem_lat = 10;
    clear_logs();
    l2_write(32'h0000_0200, dat_a, lat);
    l2_write(32'h0000_0200, dat_b, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL cstall_latency: got %0d want 11", lat); end
    wait_drained();
    checks++; if (wr_addr_log.size() != 2) begin errors++; $display("FAIL cstall_log_size: got %0d want 2", wr_addr_log.size()); end
    else begin
      checks++; if (wr_data_log[0] !== dat_a) begin errors++; $display("FAIL cstall_first: got %h want %h", wr_data_log[0], dat_a); end
      checks++; if (wr_data_log[1] !== dat_b || wr_addr_log[1] !== 32'h200) begin errors++; $display("FAIL cstall_second: got %h/%h want 00000200/%h", wr_addr_log[1], wr_data_log[1], dat_b); end
    end
  endtask

  task automatic test_full_stall();
    int lat1, lat2, lat3;
    mem_lat = 10;
    clear_logs();
    l2_write(32'h0000_0000, dat_a, lat1);
    l2_write(32'h0000_0020, dat_b, lat2);
    l2_write(32'h0000_0040, dat_c, lat3);
    checks++; if (lat1 != 1 || lat2 != 1) begin errors++; $display("FAIL full_first_two: got %0d %0d want 1 1", lat1, lat2); end
    checks++; if (lat3 != 9) begin errors++; $display("FAIL full_third_latency: got %0d want 9", lat3); end
    wait_drained();
    checks++; if (wr_addr_log.size() != 3) begin errors++; $display("FAIL full_log_size: got %0d want 3", wr_addr_log.size()); end
    else begin
      checks++; if (wr_addr_log[0] !== 32'h00 || wr_addr_log[1] !== 32'h20 || wr_addr_log[2] !== 32'h40) begin
        errors++; $display("FAIL full_order: got %h %h %h want 00000000 00000020 00000040", wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]);
      end
      checks++; if (wr_data_log[2] !== dat_c) begin errors++; $display("FAIL full_third_data: got %h want %h", wr_data_log[2], dat_c); end
    end
  endtask

  task automatic test_read_miss_priority();
    int lat;
    logic [255:0] d;
    mem_lat = 10;
    clear_logs();
    l2_write(32'h0000_0300, dat_d, lat);
    l2_write(32'h0000_0320, dat_e, lat);
    @(negedge clk);
    mem_address = 32'h0000_0804;
    mem_read    = 1'b1;
    lat = 0;
    d   = '0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) begin d = mem_rdata; break; end
    end
    checks++; if (lat != 19) begin errors++; $display("FAIL prio_latency: got %0d want 19", lat); end
    checks++; if (d !== rd_pattern(32'h800)) begin errors++; $display("FAIL prio_data: got %h want %h", d, rd_pattern(32'h800)); end
    checks++; if (wr_addr_log.size() != 1) begin errors++; $display("FAIL prio_drains_before_resp: got %0d want 1", wr_addr_log.size()); end
    checks++; if (dbg_d_state !== 1'b0 || dbg_count !== 2'd1) begin errors++; $display("FAIL prio_drain_held: got d=%0d count=%0d want 0 1", dbg_d_state, dbg_count); end
    mem_read = 1'b0;
    @(posedge clk); #1;
    checks++; if (rd_addr_log.size() != 1 || rd_addr_log[0] !== 32'h800) begin errors++; $display("FAIL prio_read_addr: got %0d reads want one at 00000800", rd_addr_log.size()); end
    wait_drained();
    checks++; if (wr_addr_log.size() != 2 || wr_addr_log[1] !== 32'h320) begin errors++; $display("FAIL prio_second_drain: got %0d writes want 2 ending 00000320", wr_addr_log.size()); end
  endtask

  task automatic test_read_miss_idle();
    int lat;
    logic [255:0] d;
    mem_lat = 1;
    clear_logs();
    l2_read(32'h0000_101c, d, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL miss_latency: got %0d want 3", lat); end
    checks++; if (d !== rd_pattern(32'h1000)) begin errors++; $display("FAIL miss_data: got %h want %h", d, rd_pattern(32'h1000)); end
    checks++; if (rd_addr_log.size() != 1 || rd_addr_log[0] !== 32'h1000) begin errors++; $display("FAIL miss_aligned_addr: got %0d reads want one at 00001000", rd_addr_log.size()); end
  endtask

  task automatic test_reset_mid();
    int lat, n;
    logic [255:0] d;
    mem_lat = 10;
    clear_logs();
    l2_write(32'h0000_0400, dat_a, lat);
    n = 0;
    while (!pmem_write && n < 20) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (pmem_write !== 1'b0 || pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
      errors++; $display("FAIL rmid_outputs: got wr=%b addr=%h want 0 0", pmem_write, pmem_address);
    end
    checks++; if (dbg_count !== 2'd0 || mem_resp !== 1'b0) begin errors++; $display("FAIL rmid_count: got %0d resp=%b want 0 0", dbg_count, mem_resp); end
    @(negedge clk);
    rst_n = 1'b1;
    l2_write(32'h0000_0440, dat_e, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL rmid_next_write: got %0d want 1", lat); end
    l2_read(32'h0000_0440, d, lat);
    checks++; if (lat != 1 || d !== dat_e) begin errors++; $display("FAIL rmid_read_hit: got lat=%0d data=%h want 1 %h", lat, d, dat_e); end
    wait_drained();
    checks++; if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 32'h440) begin errors++; $display("FAIL rmid_log: got %0d writes want one at 00000440", wr_addr_log.size()); end
  endtask

  initial begin
    dat_a = {8{32'hAAAA_0001}};
    dat_b = {8{32'hBBBB_0002}};
    dat_c = {8{32'hCCCC_0003}};
    dat_d = {8{32'hDDDD_0004}};
    dat_e = {8{32'hEEEE_0005}};
    test_reset();
    test_single_write();
    test_read_forward();
    test_coalesce();
    test_coalesce_stall();
    test_full_stall();
    test_read_miss_priority();
    test_read_miss_idle();
    test_reset_mid();
    checks++; if (overlap_seen) begin errors++; $display("FAIL port_overlap: got pmem_read and pmem_write together want never"); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
